trace_capture_sequencer: RTL

//  Capture-control FSM in the trace_clk domain. Arms on host request, waits for a

---
 rtl/trace_capture_sequencer_if.sv | 46 ++++
 rtl/trace_capture_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_sequencer_if.sv
// Bus bundle for trace_capture_sequencer: host control/config, trigger
// sources, datapath handshake and status outputs.
//   master: host/datapath side (drives *_i, observes *_o)
//   slave : the sequencer itself (observes *_i, drives *_o)
// Clock (trace_clk) and reset stay plain ports on the sequencer.
interface trace_capture_sequencer_if #(
  parameter int unsigned pMATCH_RULES = 8,
  parameter int unsigned pCOUNT_WIDTH = 32,
  parameter int unsigned pDELAY_WIDTH = 20,
  parameter int unsigned pPULSE_WIDTH = 16
) ();
  logic                    arm_i;
  logic                    abort_i;
  logic [1:0]              trig_src_i;
  logic [pMATCH_RULES-1:0] match_mask_i;
  logic [pCOUNT_WIDTH-1:0] capture_len_i;
  logic [pDELAY_WIDTH-1:0] trig_delay_i;
  logic [pPULSE_WIDTH-1:0] trig_width_i;
  logic                    m3_trig_i;
  logic [pMATCH_RULES-1:0] match_hit_i;
  logic                    data_valid_i;
  logic                    fifo_full_i;
  logic                    armed_o;
  logic                    capturing_o;
  logic                    done_o;
  logic                    overflow_o;
  logic                    trig_out_o;
  logic [pCOUNT_WIDTH-1:0] word_count_o;
  logic [1:0]              state_o;

  modport master (
    output arm_i, abort_i, trig_src_i, match_mask_i, capture_len_i,
           trig_delay_i, trig_width_i, m3_trig_i, match_hit_i,
           data_valid_i, fifo_full_i,
    input  armed_o, capturing_o, done_o, overflow_o, trig_out_o,
           word_count_o, state_o
  );

  modport slave (
    input  arm_i, abort_i, trig_src_i, match_mask_i, capture_len_i,
           trig_delay_i, trig_width_i, m3_trig_i, match_hit_i,
           data_valid_i, fifo_full_i,
    output armed_o, capturing_o, done_o, overflow_o, trig_out_o,
           word_count_o, state_o
  );
endinterface

// File: rtl/trace_capture_sequencer.sv
// Capture-control FSM in the trace_clk domain. Arms on host request, waits
// for a trigger (m3 rising edge, match-rule hit, either, or immediate), gates
// the trace datapath for a programmed number of words and produces a
// delayed/stretched trigger-out pulse.
// Ports:
//   trace_clk : clock, all logic on posedge
//   reset     : synchronous, active-high
//   bus       : trace_capture_sequencer_if.slave
//               inputs  arm_i, abort_i, trig_src_i, match_mask_i,
//                       capture_len_i (0 = unlimited), trig_delay_i,
//                       trig_width_i (0 = no pulse), m3_trig_i, match_hit_i,
//                       data_valid_i, fifo_full_i
//               outputs armed_o, capturing_o, done_o, overflow_o (sticky),
//                       trig_out_o, word_count_o, state_o
module trace_capture_sequencer #(
  parameter int unsigned pMATCH_RULES = 8,
  parameter int unsigned pCOUNT_WIDTH = 32,
  parameter int unsigned pDELAY_WIDTH = 20,
  parameter int unsigned pPULSE_WIDTH = 16
) (
  input  logic                        trace_clk,
  input  logic                        reset,
  trace_capture_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_DELAY = 2'd1,
    PG_PULSE = 2'd2
  } pgen_e;

  state_e                  state_q;
  logic                    m3_q;
  logic [1:0]              src_q;
  logic [pMATCH_RULES-1:0] mask_q;
  logic [pCOUNT_WIDTH-1:0] len_q;
  logic [pDELAY_WIDTH-1:0] dly_q;
  logic [pPULSE_WIDTH-1:0] wid_q;
  logic [pCOUNT_WIDTH-1:0] count_q;
  logic [pCOUNT_WIDTH-1:0] count_d;
  logic                    ovf_q;

  pgen_e                   pg_q;
  logic [pDELAY_WIDTH-1:0] dcnt_q;
  logic [pPULSE_WIDTH-1:0] wcnt_q;
  logic [pPULSE_WIDTH-1:0] pw_q;
  logic                    trig_out_q;

  logic m3_rise;
  logic match_any;
  logic trg;
  logic trg_fire;
  logic accept;
  logic len_reached;

  assign m3_rise   = bus.m3_trig_i & ~m3_q;
  assign match_any = |(bus.match_hit_i & mask_q);

  always_comb begin
    trg = 1'b0;
    unique case (src_q)
      2'd0:    trg = m3_rise;
      2'd1:    trg = match_any;
      2'd2:    trg = m3_rise | match_any;
      default: trg = 1'b1;
    endcase
  end

  // Abort outranks a trigger seen in the same cycle.
  assign trg_fire = (state_q == ST_ARMED) & trg & ~bus.abort_i;
  assign accept   = bus.data_valid_i & ~bus.fifo_full_i;

  // Saturating increment so an unlimited capture cannot wrap the count.
  assign count_d     = (count_q == '1) ? count_q : count_q + pCOUNT_WIDTH'(1);
  assign len_reached = (len_q != '0) && (count_d == len_q);

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m3_q    <= 1'b0;
      src_q   <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      m3_q <= bus.m3_trig_i;
      if (bus.abort_i) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (bus.arm_i) begin
              state_q <= ST_ARMED;
              count_q <= '0;
              ovf_q   <= 1'b0;
              src_q   <= bus.trig_src_i;
              mask_q  <= bus.match_mask_i;
              len_q   <= bus.capture_len_i;
              dly_q   <= bus.trig_delay_i;
              wid_q   <= bus.trig_width_i;
            end
          end
          ST_ARMED: begin
            if (trg) state_q <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (accept) count_q <= count_d;
            if (bus.data_valid_i && bus.fifo_full_i) ovf_q <= 1'b1;
            if (bus.fifo_full_i || (accept && len_reached)) state_q <= ST_DONE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Trigger-out generator: runs on its own once started so the pulse can
  // outlive the capture; only abort or reset cut it short. A trigger while a
  // pulse is still pending/high is ignored so that pulse completes intact.
  always_ff @(posedge trace_clk) begin
    if (reset || bus.abort_i) begin
      pg_q       <= PG_IDLE;
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      pw_q       <= '0;
      trig_out_q <= 1'b0;
    end else begin
      unique case (pg_q)
        PG_IDLE: begin
          if (trg_fire && (wid_q != '0)) begin
            pw_q <= wid_q;
            if (dly_q == '0) begin
              pg_q       <= PG_PULSE;
              trig_out_q <= 1'b1;
              wcnt_q     <= wid_q - pPULSE_WIDTH'(1);
            end else begin
              pg_q   <= PG_DELAY;
              dcnt_q <= dly_q - pDELAY_WIDTH'(1);
            end
          end
        end
        PG_DELAY: begin
          if (dcnt_q == '0) begin
            pg_q       <= PG_PULSE;
            trig_out_q <= 1'b1;
            wcnt_q     <= pw_q - pPULSE_WIDTH'(1);
          end else begin
            dcnt_q <= dcnt_q - pDELAY_WIDTH'(1);
          end
        end
        PG_PULSE: begin
          if (wcnt_q == '0) begin
            pg_q       <= PG_IDLE;
            trig_out_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - pPULSE_WIDTH'(1);
          end
        end
        default: begin
          pg_q       <= PG_IDLE;
          trig_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.armed_o      = (state_q == ST_ARMED);
  assign bus.capturing_o  = (state_q == ST_CAPTURE);
  assign bus.done_o       = (state_q == ST_DONE);
  assign bus.overflow_o   = ovf_q;
  assign bus.trig_out_o   = trig_out_q;
  assign bus.word_count_o = count_q;
  assign bus.state_o      = state_q;

endmodule
